ones_pattern_gen: RTL and testbench

- Inverse companion to the team's combinational ones-counter.
- Given a requested ones-count N, the block enumerates every DATAWIDTH-bit word whose popcount is exactly N.
- Words come out in strictly ascending numeric order, one per accepted valid/ready beat.
- Used as a stimulus/pattern source for weight-based checkers and as a constant-weight code generator feeding downstream logic.

---
 rtl/ones_pattern_pkg.sv | 33 +++
 rtl/ones_pattern_gen_if.sv | 26 ++
 rtl/ones_pattern_gen_next_perm.sv | 35 +++
 rtl/ones_pattern_gen.sv | 99 +++++++++
 tb/tb_ones_pattern_gen.sv | 141 ++++++++++++++
 5 files changed

// File: rtl/ones_pattern_pkg.sv
// Shared types and mask helpers for the constant-weight word enumerator.
// Pure declarations: no latency or flow-control behaviour of its own.
package ones_pattern_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int DATAWIDTH_DEFAULT = 16;
  localparam int CNTW              = $clog2(DATAWIDTH_DEFAULT) + 1;
  localparam int MASKW             = 64;

  // n ones packed at the bottom: the first (smallest) word of a run.
  function automatic logic [MASKW-1:0] low_mask(input int n);
    logic [MASKW-1:0] m;
    m = '0;
    for (int i = 0; i < MASKW; i++) begin
      m[i] = (i < n);
    end
    return m;
  endfunction

  function automatic logic [MASKW-1:0] top_mask(input int dw, input int n);
    logic [MASKW-1:0] m;
    m = '0;
    for (int i = 0; i < MASKW; i++) begin
      m[i] = (i >= dw - n) && (i < dw);
    end
    return m;
  endfunction

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Request/stream bundle between the pattern generator and its user.
// The generator holds its output word stable until i_Ready is seen with o_Valid.
interface ones_pattern_gen_if #(
  parameter int DATAWIDTH = 16,
  parameter int CNTW      = $clog2(DATAWIDTH) + 1
);
  logic                 i_Start;
  logic [CNTW-1:0]      i_Count;
  logic                 i_Ready;
  logic                 o_Valid;
  logic [DATAWIDTH-1:0] o_Data;
  logic                 o_Last;
  logic [DATAWIDTH-1:0] o_Index;
  logic                 o_Busy;
  logic                 o_Error;

  modport master (
    output i_Start, i_Count, i_Ready,
    input  o_Valid, o_Data, o_Last, o_Index, o_Busy, o_Error
  );

  modport slave (
    input  i_Start, i_Count, i_Ready,
    output o_Valid, o_Data, o_Last, o_Index, o_Busy, o_Error
  );
endinterface

// File: rtl/ones_pattern_gen_next_perm.sv
// Next-larger word with the same popcount (Gosper), no divider.
// Purely combinational; zero latency, no flow control.
module ones_next_perm #(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] x,
  output logic [DATAWIDTH-1:0] next
);
  localparam int TZW = $clog2(DATAWIDTH + 1);

  logic [DATAWIDTH-1:0] lsb;
  logic [DATAWIDTH:0]   sum;
  logic [DATAWIDTH:0]   flip;
  logic [DATAWIDTH:0]   nxt_full;
  logic [TZW-1:0]       tz;
  logic                 carry_unused;

  assign lsb = x & (~x + DATAWIDTH'(1));
  assign sum = {1'b0, x} + {1'b0, lsb};

  // Lowest set bit wins; an all-zero word reports DATAWIDTH.
  always_comb begin
    tz = TZW'(DATAWIDTH);
    for (int i = DATAWIDTH - 1; i >= 0; i--) begin
      if (x[i]) tz = TZW'(i);
    end
  end

  assign flip     = (sum ^ {1'b0, x}) >> 2;
  assign nxt_full = sum | (flip >> tz);

  // The final word of a run is never advanced, so the carry never matters.
  assign next         = nxt_full[DATAWIDTH-1:0];
  assign carry_unused = nxt_full[DATAWIDTH];
endmodule

// File: rtl/ones_pattern_gen.sv
// Enumerates every DATAWIDTH-bit word of popcount N in ascending order, one per beat.
// First word one cycle after start; o_Data/o_Index/o_Last hold while i_Ready is low.
module ones_pattern_gen
  import ones_pattern_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEFAULT
) (
  input logic               i_Clk,
  input logic               i_Rst,
  ones_pattern_gen_if.slave bus
);
  localparam int CW = $clog2(DATAWIDTH) + 1;

  state_e               state_q, state_d;
  logic [CW-1:0]        n_q, n_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] idx_q, idx_d;
  logic                 last_q, last_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [DATAWIDTH-1:0] next_word;
  logic [DATAWIDTH-1:0] last_word;
  logic                 handshake;

  ones_next_perm #(.DATAWIDTH(DATAWIDTH)) u_next_perm (
    .x    (data_q),
    .next (next_word)
  );

  assign last_word = DATAWIDTH'(top_mask(DATAWIDTH, int'(n_q)));
  assign handshake = valid_q & bus.i_Ready;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.i_Start) begin
          if (bus.i_Count > CW'(DATAWIDTH)) begin
            err_d = 1'b1;
          end else begin
            n_d     = bus.i_Count;
            data_d  = DATAWIDTH'(low_mask(int'(bus.i_Count)));
            idx_d   = '0;
            last_d  = (bus.i_Count == '0) || (bus.i_Count == CW'(DATAWIDTH));
            valid_d = 1'b1;
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (handshake) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = IDLE;
          end else begin
            data_d = next_word;
            idx_d  = idx_q + DATAWIDTH'(1);
            last_d = (next_word == last_word);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_Valid = valid_q;
  assign bus.o_Data  = data_q;
  assign bus.o_Last  = last_q;
  assign bus.o_Index = idx_q;
  assign bus.o_Busy  = (state_q == EMIT);
  assign bus.o_Error = err_q;
endmodule

// File: tb/tb_ones_pattern_gen.sv
// Bench for ones_pattern_gen: reference word lists come from a brute-force popcount scan.
// Outputs sampled and inputs driven on the falling clock edge.
module tb_ones_pattern_gen;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst;

  ones_pattern_gen_if #(.DATAWIDTH(DW)) bus ();

  ones_pattern_gen #(.DATAWIDTH(DW)) dut (
    .i_Clk (clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [DW-1:0] ref_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Every DW-bit value whose popcount is n, ascending by construction.
  task automatic build_ref(input int n);
    logic [DW-1:0] w;
    ref_q.delete();
    for (int v = 0; v < (1 << DW); v++) begin
      w = DW'(v);
      if ($countones(w) == n) ref_q.push_back(w);
    end
  endtask

  task automatic run(input int n, input bit rnd_ready, input int count,
                     input bit abort5, input int inject_at, input logic [DW-1:0] exp_last);
    int k = 0;
    int cycles = 0;
    int stop;
    int budget;
    bit rdy;
    logic [DW-1:0] prev = '0;
    build_ref(n);
    stop   = abort5 ? 5 : count;
    budget = count * 8 + 20;
    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Count = 5'(n);
    bus.i_Ready = 1'b0;
    while (k < stop && cycles < budget) begin
      @(negedge clk);
      cycles++;
      bus.i_Start = 1'b0;
      if (k == inject_at) begin
        bus.i_Start = 1'b1;
        bus.i_Count = 5'd1;
      end
      check("busy_in_run", 32'(bus.o_Busy), 32'd1);
      check("no_error_in_run", 32'(bus.o_Error), 32'd0);
      check("valid_in_run", 32'(bus.o_Valid), 32'd1);
      check("data", 32'(bus.o_Data), 32'(ref_q[k]));
      check("index", 32'(bus.o_Index), 32'(k));
      check("last_flag", 32'(bus.o_Last), 32'(k == count - 1));
      check("popcount", 32'($countones(bus.o_Data)), 32'(n));
      if (k > 0) check("ascending", 32'(bus.o_Data > prev), 32'd1);
      if (k == count - 1) check("final_word", 32'(bus.o_Data), 32'(exp_last));
      rdy = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.i_Ready = rdy;
      if (rdy) begin
        prev = bus.o_Data;
        k++;
      end
    end
    bus.i_Start = 1'b0;
    check("words_transferred", 32'(k), 32'(stop));
    @(negedge clk);
    bus.i_Ready = 1'b0;
    if (!abort5) begin
      check("valid_after_run", 32'(bus.o_Valid), 32'd0);
      check("busy_after_run", 32'(bus.o_Busy), 32'd0);
      check("last_after_run", 32'(bus.o_Last), 32'd0);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.i_Start = 1'b0;
    bus.i_Count = '0;
    bus.i_Ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.o_Valid), 32'd0);
    check("rst_data", 32'(bus.o_Data), 32'd0);
    check("rst_last", 32'(bus.o_Last), 32'd0);
    check("rst_index", 32'(bus.o_Index), 32'd0);
    check("rst_busy", 32'(bus.o_Busy), 32'd0);
    check("rst_error", 32'(bus.o_Error), 32'd0);
    rst = 1'b0;

    run(0, 1'b0, 1, 1'b0, -1, 16'h0000);
    run(1, 1'b0, 16, 1'b0, -1, 16'h8000);
    run(2, 1'b0, 120, 1'b0, -1, 16'hC000);
    run(16, 1'b0, 1, 1'b0, -1, 16'hFFFF);

    @(negedge clk);
    bus.i_Start = 1'b1;
    bus.i_Count = 5'd17;
    @(negedge clk);
    bus.i_Start = 1'b0;
    check("err_pulse", 32'(bus.o_Error), 32'd1);
    check("err_no_valid", 32'(bus.o_Valid), 32'd0);
    check("err_no_busy", 32'(bus.o_Busy), 32'd0);
    @(negedge clk);
    check("err_one_cycle", 32'(bus.o_Error), 32'd0);
    check("err_still_no_valid", 32'(bus.o_Valid), 32'd0);
    check("err_still_no_busy", 32'(bus.o_Busy), 32'd0);

    run(3, 1'b1, 560, 1'b0, -1, 16'hE000);

    run(2, 1'b0, 120, 1'b1, -1, 16'hC000);
    check("pre_reset_index", 32'(bus.o_Index), 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.o_Valid), 32'd0);
    check("mid_rst_busy", 32'(bus.o_Busy), 32'd0);
    check("mid_rst_data", 32'(bus.o_Data), 32'd0);
    check("mid_rst_index", 32'(bus.o_Index), 32'd0);

    run(4, 1'b0, 1820, 1'b0, 100, 16'hF000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
